fwnoc_out_arb: RTL and testbench
================================

# fwnoc_out_arb

Output-port arbiter for the fwnoc router. It shares one router output port (host, north, south, east or west) between the N_PORTS input ports that can route to it. Arbitration is round-robin with wormhole packet locking: a grant is held from the header flit through the last body flit of a packet. One instance sits in front of each router output. Its request and output channels are the ready/valid streams the router debug monitor taps.

## Interface
- N_PORTS, 5: number of requesting input ports; must be ≥2.
- DAT_W, 32: flit width.
- LEN_LSB, 0: LSB of the 8-bit body-length field in the header flit (bits LEN_LSB+7:LEN_LSB).

- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_dat  in  N_PORTS*DAT_W  request flits; port i at [i*DAT_W +: DAT_W].
- req_valid  in  N_PORTS  per-port flit valid.
- req_ready  out  N_PORTS  per-port flit accepted.
- out_dat  out  DAT_W  selected flit.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream ready.
- grant  out  N_PORTS  one-hot current owner; 0 when no owner.
- busy  out  1  high in HDR_WAIT or BODY.

## Operation
- Transfer on a channel = valid && ready in the same cycle.
- Header flit: first flit of a packet. The 8-bit length L at LEN_LSB counts the body flits that follow, so the packet is L+1 flits (1..256).
- Datapath is combinational, with no storage:
  - out_dat = req_dat[g] and out_valid = req_valid[g], where g is the current owner.
  - req_ready[i] = out_ready && grant[i].
  - Non-owners see req_ready=0.
- State: 2-bit FSM {IDLE, HDR_WAIT, BODY}, rr pointer ptr (clog2(N_PORTS) bits), owner register own, 8-bit body counter cnt.
- IDLE:
  - g = first i with req_valid[i], searching from ptr upward modulo N_PORTS. No valid input gives grant=0 and out_valid=0.
  - Header transfers with L=0: stay IDLE, ptr←(g+1) mod N_PORTS.
  - Header transfers with L>0: go to BODY, own←g, cnt←L.
  - Valid g but no transfer (out_ready=0): go to HDR_WAIT, own←g.
- HDR_WAIT:
  - grant = own, held regardless of other requests, so out_dat/out_valid stay stable while stalled.
  - Header transfer with L=0: go to IDLE, ptr←own+1.
  - Header transfer with L>0: go to BODY, cnt←L.
- BODY:
  - grant = own; every transfer decrements cnt.
  - Transfer when cnt==1: go to IDLE, ptr←(own+1) mod N_PORTS.
  - Owner valid low: bubble, no state change.
- ptr wrap: own=N_PORTS-1 gives ptr←0.
- Requesters are ready/valid-compliant (valid and data held until accepted); the arbiter does not check this.
- Reset mid-packet: FSM←IDLE, ptr←0, cnt←0, own←0. The remainder of the abandoned packet is then arbitrated as a new header. Upstream must be reset together with the arbiter.

## Timing
- Reset values: FSM=IDLE, ptr=0, own=0, cnt=0.
  - While reset is asserted, out_valid=0, req_ready=0, grant=0 and busy=0 (forced).
  - After release, outputs follow the combinational rules above.
- Latency: 0 cycles. A flit offered in cycle t appears on out_* in cycle t.
- Throughput: one flit per cycle, including back-to-back packets from different ports with no idle cycle between them. The IDLE decision occurs in the same cycle as the next header.
- The arbitration decision takes effect only at a packet boundary. No other port is granted between the header and body flit L.
- A stalled header (out_ready=0) keeps the same grant on every following cycle until it transfers.

## Test plan
- Single port 2, L=3 header then 3 body flits, out_ready=1: 4 consecutive out transfers with grant=0b00100. Returns to IDLE after flit 4 with ptr=3.
- Ports 0,1,4 all valid with L=0 headers continuously, ptr=0: grant sequence 0,1,4,0,1,4. One flit per cycle; no port is starved.
- Port 1 has an L=2 packet in BODY and port 0 asserts valid: port 0 receives req_ready=0 until port 1's third flit transfers. Port 0 is granted in the next cycle, since ptr=2 wraps to the first valid port, 0.
- Port 3 header stalled with out_ready=0 for 5 cycles while port 1 raises valid: grant stays 0b01000 and out_dat stays constant. The header transfers when out_ready=1.
- L=255 packet from port 4 with random out_ready and owner valid bubbles: exactly 256 transfers and cnt reaches 0. FSM returns to IDLE with ptr wrapping to 0.
- Reset asserted during BODY of an L=5 packet after 2 body flits: outputs are 0 immediately and asynchronously. After release FSM=IDLE and ptr=0, and the next offered flit is treated as a header.

Source files
------------

// File: rtl/fwnoc_out_arb.sv
// Output-port arbiter for one fwnoc router output: round-robin selection among the
// input ports, with the grant locked from a packet's header flit through its last body flit.
module fwnoc_out_arb #(
    parameter int N_PORTS = 5,
    parameter int DAT_W   = 32,
    parameter int LEN_LSB = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_PORTS*DAT_W-1:0] req_dat,
    input  logic [N_PORTS-1:0]       req_valid,
    output logic [N_PORTS-1:0]       req_ready,
    output logic [DAT_W-1:0]         out_dat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_PORTS-1:0]       grant,
    output logic                     busy
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HDR_WAIT = 2'd1,
        S_BODY     = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [PW-1:0]   r_own;
    logic [PW-1:0]   w_own_nxt;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_nxt;
    logic [PW-1:0]   w_sel;
    logic [PW-1:0]   w_idx;
    logic [PW-1:0]   w_probe;
    logic            w_found;
    logic            w_owned;
    logic            w_xfer;
    logic [7:0]      w_len;
    logic [N_PORTS-1:0] w_onehot;

    function automatic logic [PW-1:0] incWrap(input logic [PW-1:0] x);
        if (int'(x) == N_PORTS - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    // Downward scan so the port closest to r_ptr (smallest offset) is the last writer and wins.
    always_comb begin
        int j;
        w_sel   = r_ptr;
        w_found = 1'b0;
        w_probe = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            j = int'(r_ptr) + k;
            if (j >= N_PORTS) begin
                j = j - N_PORTS;
            end
            w_probe = PW'(j);
            if (req_valid[w_probe]) begin
                w_sel   = w_probe;
                w_found = 1'b1;
            end
        end
    end

    assign w_idx   = (r_state == S_IDLE) ? w_sel : r_own;
    assign w_owned = reset && ((r_state != S_IDLE) || w_found);

    always_comb begin
        w_onehot = '0;
        out_dat  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (int'(w_idx) == i) begin
                w_onehot[i] = 1'b1;
                out_dat     = req_dat[i*DAT_W +: DAT_W];
            end
        end
    end

    assign grant     = w_owned ? w_onehot : '0;
    assign out_valid = w_owned && req_valid[w_idx];
    assign req_ready = out_ready ? grant : '0;
    assign busy      = reset && (r_state != S_IDLE);
    assign w_xfer    = out_valid && out_ready;
    assign w_len     = out_dat[LEN_LSB +: 8];

    // The ptr only advances when a packet finishes, so the owner is fixed for its whole length.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_own_nxt   = r_own;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    if (!w_xfer) begin
                        w_state_nxt = S_HDR_WAIT;
                        w_own_nxt   = w_sel;
                    end else if (w_len == 8'd0) begin
                        w_ptr_nxt = incWrap(w_sel);
                    end else begin
                        w_state_nxt = S_BODY;
                        w_own_nxt   = w_sel;
                        w_cnt_nxt   = w_len;
                    end
                end
            end
            S_HDR_WAIT: begin
                if (w_xfer) begin
                    if (w_len == 8'd0) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = incWrap(r_own);
                    end else begin
                        w_state_nxt = S_BODY;
                        w_cnt_nxt   = w_len;
                    end
                end
            end
            S_BODY: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = incWrap(r_own);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_own   <= w_own_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fwnoc_out_arb.sv
// Self-checking bench for fwnoc_out_arb: a table of hand-derived vectors plus
// hand-written sequences for the long packet and the mid-packet reset.
module tb_fwnoc_out_arb;

    localparam int N  = 5;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   out_dat;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            busy;

    fwnoc_out_arb #(.N_PORTS(N), .DAT_W(DW), .LEN_LSB(0)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_dat   (req_dat),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .out_dat   (out_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  grant;
        logic        outValid;
        logic [31:0] outDat;
        logic [4:0]  reqReady;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [4:0]  valid;
        logic [39:0] lens;
        logic        outReady;
        logic [4:0]  expGrant;
        logic        expBusy;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   hdrSent;
    int   xfers;
    int   cyc;
    logic v4;
    logic ordy;

    function automatic logic [31:0] makeDat(input int port, input logic [7:0] len);
        return {8'hD0 | 8'(port), 8'h3C, 8'(port * 17), len};
    endfunction

    task automatic addVec(input logic [4:0] valid, input logic [39:0] lens, input logic ordyIn,
                          input logic [4:0] expGrant, input logic expBusy);
        vec_t v;
        v.valid    = valid;
        v.lens     = lens;
        v.outReady = ordyIn;
        v.expGrant = expGrant;
        v.expBusy  = expBusy;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [4:0] valid, input logic [39:0] lens, input logic ordyIn,
                                 input logic [4:0] expGrant, input logic expBusy);
        exp_t e;
        req_valid = valid;
        out_ready = ordyIn;
        for (int i = 0; i < N; i++) begin
            req_dat[i*DW +: DW] = makeDat(i, lens[i*8 +: 8]);
        end
        e.grant    = expGrant;
        e.outValid = |(expGrant & valid);
        e.reqReady = ordyIn ? expGrant : 5'b0;
        e.busy     = expBusy;
        e.outDat   = '0;
        for (int i = 0; i < N; i++) begin
            if (expGrant[i]) begin
                e.outDat = makeDat(i, lens[i*8 +: 8]);
            end
        end
        expQ.push_back(e);
    endtask

    task automatic cmp(input string what, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", what, act, expv);
        end
    endtask

    task automatic checkOutput(input string name);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: no expected entry queued", name);
            return;
        end
        e = expQ.pop_front();
        cmp({name, " grant"}, 32'(grant), 32'(e.grant));
        cmp({name, " out_valid"}, 32'(out_valid), 32'(e.outValid));
        cmp({name, " req_ready"}, 32'(req_ready), 32'(e.reqReady));
        cmp({name, " busy"}, 32'(busy), 32'(e.busy));
        if (e.grant != 5'b0) begin
            cmp({name, " out_dat"}, out_dat, e.outDat);
        end
    endtask

    task automatic driveCycle(input string name, input logic [4:0] valid, input logic [39:0] lens,
                              input logic ordyIn, input logic [4:0] expGrant, input logic expBusy);
        @(negedge clock);
        applyStimulus(valid, lens, ordyIn, expGrant, expBusy);
        #3;
        checkOutput(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_dat   = '0;
        out_ready = 1'b0;
        #2;
        applyStimulus(5'b11111, 40'd0, 1'b1, 5'b00000, 1'b0);
        #1;
        checkOutput("reset");
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;

        // Single port 2, L=3 packet, then ptr=3 wraps through port 4 to 0.
        addVec(5'b00100, {8'd0, 8'd0, 8'd3, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b0);
        for (int i = 0; i < 3; i++) begin
            addVec(5'b00100, {8'd0, 8'd0, 8'd7, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b1);
        end
        addVec(5'b10001, 40'd0, 1'b1, 5'b10000, 1'b0);
        addVec(5'b10001, 40'd0, 1'b1, 5'b00001, 1'b0);
        addVec(5'b10000, 40'd0, 1'b1, 5'b10000, 1'b0);
        // Ports 0,1,4 back-to-back single-flit packets from ptr=0.
        for (int i = 0; i < 2; i++) begin
            addVec(5'b10011, 40'd0, 1'b1, 5'b00001, 1'b0);
            addVec(5'b10011, 40'd0, 1'b1, 5'b00010, 1'b0);
            addVec(5'b10011, 40'd0, 1'b1, 5'b10000, 1'b0);
        end
        // Port 1 L=2 packet locks out port 0 until its last flit.
        addVec(5'b00010, {8'd0, 8'd0, 8'd0, 8'd2, 8'd0}, 1'b1, 5'b00010, 1'b0);
        addVec(5'b00011, {8'd0, 8'd0, 8'd0, 8'd9, 8'd0}, 1'b1, 5'b00010, 1'b1);
        addVec(5'b00011, {8'd0, 8'd0, 8'd0, 8'd9, 8'd0}, 1'b1, 5'b00010, 1'b1);
        addVec(5'b00001, 40'd0, 1'b1, 5'b00001, 1'b0);
        // Port 3 header stalled while port 1 requests.
        addVec(5'b01000, 40'd0, 1'b0, 5'b01000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            addVec(5'b01010, 40'd0, 1'b0, 5'b01000, 1'b1);
        end
        addVec(5'b01010, 40'd0, 1'b1, 5'b01000, 1'b1);
        addVec(5'b00010, 40'd0, 1'b1, 5'b00010, 1'b0);
        addVec(5'b00000, 40'd0, 1'b1, 5'b00000, 1'b0);
        // Stalled header with L=1 goes through HDR_WAIT into BODY.
        addVec(5'b00100, {8'd0, 8'd0, 8'd1, 8'd0, 8'd0}, 1'b0, 5'b00100, 1'b0);
        addVec(5'b00100, {8'd0, 8'd0, 8'd1, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b1);
        addVec(5'b00110, {8'd0, 8'd0, 8'd5, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b1);
        addVec(5'b00010, 40'd0, 1'b1, 5'b00010, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            driveCycle($sformatf("vec%0d", i), vecs[i].valid, vecs[i].lens, vecs[i].outReady,
                       vecs[i].expGrant, vecs[i].expBusy);
        end

        // L=255 packet from port 4 with random stalls and bubbles; port 0 must never steal the grant.
        hdrSent = 0;
        xfers   = 0;
        cyc     = 0;
        while (xfers < 256 && cyc < 3000) begin
            ordy = ($urandom_range(0, 3) != 0);
            v4   = (hdrSent != 0) ? ($urandom_range(0, 4) != 0) : 1'b1;
            driveCycle("long", {v4, 4'b0001}, {((hdrSent != 0) ? 8'd200 : 8'd255), 32'd0}, ordy,
                       5'b10000, (cyc != 0));
            if (v4 && ordy) begin
                xfers++;
                hdrSent = 1;
            end
            cyc++;
        end
        if (xfers < 256) begin
            checks++;
            errors++;
            $display("[TB] FAIL long: only %0d transfers after %0d cycles, required 256", xfers, cyc);
        end
        driveCycle("longEnd", 5'b10001, 40'd0, 1'b1, 5'b00001, 1'b0);

        // Reset during the body of an L=5 packet after two body flits.
        driveCycle("rstHdr", 5'b00100, {8'd0, 8'd0, 8'd5, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b0);
        driveCycle("rstBody", 5'b00100, {8'd0, 8'd0, 8'd7, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b1);
        driveCycle("rstBody", 5'b00100, {8'd0, 8'd0, 8'd7, 8'd0, 8'd0}, 1'b1, 5'b00100, 1'b1);
        @(negedge clock);
        applyStimulus(5'b00100, {8'd0, 8'd0, 8'd7, 8'd0, 8'd0}, 1'b1, 5'b00000, 1'b0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rstMid");
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(5'b00111, 40'd0, 1'b1, 5'b00001, 1'b0);
        #3;
        checkOutput("rstPtr");
        driveCycle("rstNext", 5'b00110, 40'd0, 1'b1, 5'b00010, 1'b0);
        driveCycle("rstAsHdr", 5'b00100, 40'd0, 1'b1, 5'b00100, 1'b0);
        driveCycle("rstAfter", 5'b01100, 40'd0, 1'b1, 5'b01000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
